scan_index_gen: RTL and testbench



---
 rtl/scan_pkg.sv | 28 ++
 rtl/decoderNxM.sv | 16 +
 rtl/scan_index_gen.sv | 128 ++++++++++++
 tb/tb_scan_index_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and next-index arithmetic for the scan index generator.
package scan_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic        wrap;
    logic [31:0] next;
  } scan_next_t;

  // wrap is set when idx + step exceeds limit. Because limit fits in the index
  // width, this also covers a carry out of the index MSB.
  function automatic scan_next_t next_index(input logic [31:0] idx,
                                            input logic [31:0] step,
                                            input logic [31:0] limit);
    scan_next_t  r;
    logic [32:0] sum;
    sum    = {1'b0, idx} + {1'b0, step};
    r.next = sum[31:0];
    r.wrap = (sum > {1'b0, limit});
    return r;
  endfunction

endpackage

// File: rtl/decoderNxM.sv
// N-to-2^N one-hot decoder; compiled only when SCAN_ONEHOT_OUT_EN is defined.
`ifdef SCAN_ONEHOT_OUT_EN
module decoderNxM #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]    sel,
  output logic [2**N-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule
`endif

// File: rtl/scan_index_gen.sv
// Sweeping select-index generator with valid/ready output.
// Optional gated one-hot output under macro SCAN_ONEHOT_OUT_EN.
module scan_index_gen
  import scan_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           stop,
  input  logic           cont,
  input  logic [N-1:0]   step,
  input  logic [N-1:0]   limit,
  output logic [N-1:0]   idx,
  output logic           idx_valid,
  input  logic           idx_ready,
  output logic           busy,
  output logic           done
`ifdef SCAN_ONEHOT_OUT_EN
  ,
  output logic [2**N-1:0] sel_onehot
`endif
);

  scan_state_e state_q, state_d;
  logic [N-1:0] idx_q, idx_d;
  logic [N-1:0] step_q, step_d;
  logic [N-1:0] limit_q, limit_d;
  logic         cont_q, cont_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  scan_next_t   nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      step_q  <= '0;
      limit_q <= '0;
      cont_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      limit_q <= limit_d;
      cont_q  <= cont_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    step_d  = step_q;
    limit_d = limit_q;
    cont_d  = cont_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    nxt     = next_index(32'(idx_q), 32'(step_q), 32'(limit_q));

    // Abort overrides everything, including a concurrent start or transfer.
    if (stop) begin
      state_d = StIdle;
      idx_d   = '0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            step_d  = (step == '0) ? N'(1) : step;
            limit_d = limit;
            cont_d  = cont;
            idx_d   = '0;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            state_d = StRun;
          end else begin
            state_d = StIdle;
          end
        end
        StRun: begin
          if (valid_q && idx_ready) begin
            if (!nxt.wrap) begin
              idx_d = N'(nxt.next);
            end else if (cont_q) begin
              idx_d = '0;
            end else begin
              valid_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = StDone;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign idx       = idx_q;
  assign idx_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef SCAN_ONEHOT_OUT_EN
  localparam int unsigned M = 2**N;
  logic [M-1:0] dec_onehot;

  decoderNxM #(
    .N(N)
  ) u_dec (
    .sel    (idx_q),
    .onehot (dec_onehot)
  );

  assign sel_onehot = valid_q ? dec_onehot : '0;
`endif

endmodule

// File: tb/tb_scan_index_gen.sv
// Self-checking bench for scan_index_gen: table-driven sweeps with a scoreboard
// queue, plus hand-written reset, continuous and stop sequences.
module tb_scan_index_gen;
  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         cont = 1'b0;
  logic         idx_ready = 1'b0;
  logic [N-1:0] step = '0;
  logic [N-1:0] limit = '0;
  logic [N-1:0] idx;
  logic         idx_valid, busy, done;
`ifdef SCAN_ONEHOT_OUT_EN
  logic [2**N-1:0] sel_onehot;
`endif

  always #5 clk = ~clk;

  scan_index_gen #(
    .N(N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .cont      (cont),
    .step      (step),
    .limit     (limit),
    .idx       (idx),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .busy      (busy),
    .done      (done)
`ifdef SCAN_ONEHOT_OUT_EN
    ,
    .sel_onehot(sel_onehot)
`endif
  );

  typedef struct {
    logic [N-1:0] step;
    logic [N-1:0] limit;
    logic [3:0]   pat;  // idx_ready pattern, bit k used on handshake cycle k%4
  } vec_t;

  vec_t         vecs[7];
  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_sweep(input logic [N-1:0] s_in, input logic [N-1:0] lim);
    int s;
    int e;
    s = (s_in == '0) ? 1 : int'(s_in);
    e = 0;
    while (e <= int'(lim)) begin
      exp_q.push_back(N'(e));
      e += s;
    end
  endtask

`ifdef SCAN_ONEHOT_OUT_EN
  always @(negedge clk) begin
    chk("onehot", 32'(sel_onehot), idx_valid ? (32'd1 << idx) : 32'd0);
  end
`endif

  // Called at a negedge; returns at the negedge where done should be high.
  task automatic run_single(input vec_t v);
    bit           last;
    bit           stalled;
    logic [N-1:0] held;
    push_sweep(v.step, v.limit);
    start     = 1'b1;
    cont      = 1'b0;
    step      = v.step;
    limit     = v.limit;
    idx_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    step  = 4'hf;  // must have been latched already
    limit = 4'h0;
    chk("first_valid", 32'(idx_valid), 1);
    chk("first_idx", 32'(idx), 0);
    chk("busy_run", 32'(busy), 1);
    last    = 1'b0;
    stalled = 1'b0;
    held    = '0;
    for (int g = 0; g < 64 && !last; g++) begin
      chk("done_early", 32'(done), 0);
      if (stalled) begin
        chk("stall_hold_idx", 32'(idx), 32'(held));
        chk("stall_hold_valid", 32'(idx_valid), 1);
      end
      idx_ready = v.pat[g % 4];
      stalled   = idx_valid && !idx_ready;
      held      = idx;
      if (idx_valid && idx_ready) begin
        chk("sweep_idx", 32'(idx), 32'(exp_q.pop_front()));
        if (exp_q.size() == 0) last = 1'b1;
      end
      @(negedge clk);
    end
    if (!last) begin
      checks++;
      errors++;
      $display("FAIL sweep_timeout: got %0d pending indices, expected 0", exp_q.size());
    end
    idx_ready = 1'b0;
    chk("done_pulse", 32'(done), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_valid", 32'(idx_valid), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{step: 4'd1,  limit: 4'd3,  pat: 4'b1111};
    vecs[1] = '{step: 4'd2,  limit: 4'd6,  pat: 4'b1001};
    vecs[2] = '{step: 4'd0,  limit: 4'd2,  pat: 4'b1111};
    vecs[3] = '{step: 4'd5,  limit: 4'd3,  pat: 4'b1111};
    vecs[4] = '{step: 4'd1,  limit: 4'd15, pat: 4'b1111};
    vecs[5] = '{step: 4'd15, limit: 4'd15, pat: 4'b1111};
    vecs[6] = '{step: 4'd3,  limit: 4'd10, pat: 4'b0101};

    repeat (2) @(negedge clk);
    chk("rst_idx", 32'(idx), 0);
    chk("rst_valid", 32'(idx_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back single sweeps; each re-arms from the DONE state.
    for (int i = 0; i < 7; i++) run_single(vecs[i]);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);

    // Continuous sweep with wrap; start in RUN ignored; stop with a transfer.
    push_sweep(4'd3, 4'd15);
    push_sweep(4'd3, 4'd3);
    start = 1'b1;
    cont  = 1'b1;
    step  = 4'd3;
    limit = 4'd15;
    @(negedge clk);
    start = 1'b0;
    n     = 0;
    for (int g = 0; g < 40 && n < 8; g++) begin
      start     = 1'b0;
      idx_ready = 1'b1;
      if (idx_valid) begin
        chk("cont_idx", 32'(idx), 32'(exp_q.pop_front()));
        n++;
        if (n == 2) begin
          start = 1'b1;
          step  = 4'd1;
        end
        if (n == 8) stop = 1'b1;
      end
      @(negedge clk);
    end
    chk("cont_count", 32'(n), 8);
    stop      = 1'b0;
    start     = 1'b0;
    idx_ready = 1'b0;
    chk("stop_valid", 32'(idx_valid), 0);
    chk("stop_busy", 32'(busy), 0);
    chk("stop_idx", 32'(idx), 0);
    chk("stop_no_done", 32'(done), 0);
    @(negedge clk);
    chk("stop_no_done2", 32'(done), 0);
    exp_q.delete();

    // Stop beats start in the same cycle.
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("stopstart_busy", 32'(busy), 0);
    chk("stopstart_valid", 32'(idx_valid), 0);

    // Asynchronous reset mid-sweep at idx 5.
    start = 1'b1;
    cont  = 1'b1;
    step  = 4'd1;
    limit = 4'd15;
    @(negedge clk);
    start     = 1'b0;
    idx_ready = 1'b1;
    for (int g = 0; g < 20 && idx != 4'd5; g++) @(negedge clk);
    chk("pre_reset_idx", 32'(idx), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_idx", 32'(idx), 0);
    chk("areset_valid", 32'(idx_valid), 0);
    chk("areset_busy", 32'(busy), 0);
    chk("areset_done", 32'(done), 0);
    idx_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
